// File: rtl/matrix_pkg.sv
// Shared constants, format struct and state encodings for the 8x8 operand loader.
package matrix_pkg;
  localparam int N             = 8;
  localparam int BEATS         = 128;
  localparam int BEAT_W        = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam int DEFAULT_WIDTH = 16;

  typedef logic [2*DEFAULT_WIDTH-1:0] elem_t;

  typedef struct packed {
    logic [4:0] m_bit1;
    logic [4:0] m_bit2;
    logic       flag;
  } fmt_t;

  typedef enum logic {WR_FILL = 1'b0, WR_FULL = 1'b1} wr_state_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_HOLD = 1'b1} rd_state_e;

  // Beat index layout: bit 6 selects B, bits 5:3 row, bits 2:0 column.
  function automatic logic beat_is_b(input logic [BEAT_W-1:0] beat);
    return beat[BEAT_W-1];
  endfunction

  function automatic logic [2:0] beat_row(input logic [BEAT_W-1:0] beat);
    return beat[5:3];
  endfunction

  function automatic logic [2:0] beat_col(input logic [BEAT_W-1:0] beat);
    return beat[2:0];
  endfunction
endpackage

// File: rtl/matrix_bank.sv
// One A+B 8x8 operand store with indexed write port, format capture and full flag.
module matrix_bank
  import matrix_pkg::*;
#(
  parameter int width = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_wr_en,
  input  logic [BEAT_W-1:0]                 i_wr_idx,
  input  logic [2*width-1:0]                i_wr_data,
  input  logic [4:0]                        i_m_bit1,
  input  logic [4:0]                        i_m_bit2,
  input  logic                              i_flag,
  input  logic                              i_set_full,
  input  logic                              i_clr,
  output logic [N-1:0][N-1:0][2*width-1:0]  o_a,
  output logic [N-1:0][N-1:0][2*width-1:0]  o_b,
  output logic [4:0]                        o_m_bit1,
  output logic [4:0]                        o_m_bit2,
  output logic                              o_flag,
  output logic                              o_full
);
  logic [N-1:0][N-1:0][2*width-1:0] r_a;
  logic [N-1:0][N-1:0][2*width-1:0] r_b;
  fmt_t                             r_fmt;
  wr_state_e                        r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_fmt   <= '0;
      r_state <= WR_FILL;
    end else begin
      if (i_wr_en) begin
        if (beat_is_b(i_wr_idx))
          r_b[beat_row(i_wr_idx)][beat_col(i_wr_idx)] <= i_wr_data;
        else
          r_a[beat_row(i_wr_idx)][beat_col(i_wr_idx)] <= i_wr_data;
        // Format travels only with the first beat of a frame.
        if (i_wr_idx == '0)
          r_fmt <= '{m_bit1: i_m_bit1, m_bit2: i_m_bit2, flag: i_flag};
      end
      if (i_set_full)
        r_state <= WR_FULL;
      else if (i_clr)
        r_state <= WR_FILL;
    end
  end

  assign o_a      = r_a;
  assign o_b      = r_b;
  assign o_m_bit1 = r_fmt.m_bit1;
  assign o_m_bit2 = r_fmt.m_bit2;
  assign o_flag   = r_fmt.flag;
  assign o_full   = (r_state == WR_FULL);
endmodule

// File: rtl/matrix_load8.sv
// Streams 128-beat frames into operand banks and presents them to an 8x8 multiplier.
// Build option PINGPONG_EN: two banks so the next frame loads while the current one is held.
module matrix_load8
  import matrix_pkg::*;
#(
  parameter int width       = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [2*width-1:0]   s_data,
  input  logic [4:0]           s_m_bit1,
  input  logic [4:0]           s_m_bit2,
  input  logic                 s_flag,
  output logic [2*width-1:0]   A [N][N],
  output logic [2*width-1:0]   B [N][N],
  output logic [4:0]           m_bit1,
  output logic [4:0]           m_bit2,
  output logic                 flag,
  output logic                 op_valid,
  output logic                 res_valid
);
  localparam int             EW        = 2 * width;
  localparam int             CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic           HOLD_ONE  = (HOLD_CYCLES == 1);

  logic                      r_ready_en;
  logic [BEAT_W-1:0]         r_beat;
  rd_state_e                 r_rd_state;
  logic                      r_op_valid;
  logic                      r_res_valid;
  logic [CW-1:0]             r_hold_cnt;

  logic                      w_hs;
  logic                      w_last;
  logic                      w_hold_end;
  logic                      w_next_avail;
  logic [N-1:0][N-1:0][EW-1:0] w_pa;
  logic [N-1:0][N-1:0][EW-1:0] w_pb;
  logic [4:0]                w_pm1;
  logic [4:0]                w_pm2;
  logic                      w_pfl;

  assign w_hs       = s_valid & s_ready;
  assign w_last     = w_hs && (r_beat == LAST_BEAT);
  assign w_hold_end = r_res_valid;

`ifdef PINGPONG_EN
  logic                        r_wr_sel;
  logic                        r_rd_sel;
  logic [1:0]                  w_full;
  logic [1:0]                  w_set;
  logic [1:0]                  w_avail;
  logic [N-1:0][N-1:0][EW-1:0] w_a0, w_a1, w_b0, w_b1;
  logic [4:0]                  w_m1_0, w_m1_1, w_m2_0, w_m2_1;
  logic                        w_fl_0, w_fl_1;

  assign w_set   = {w_last & r_wr_sel, w_last & ~r_wr_sel};
  assign w_avail = w_full | w_set;
  assign s_ready = r_ready_en & ~(r_wr_sel ? w_full[1] : w_full[0]);
  // While holding, the candidate is the other bank; when idle, the bank next in order.
  assign w_next_avail = r_op_valid ? (r_rd_sel ? w_avail[0] : w_avail[1])
                                   : (r_rd_sel ? w_avail[1] : w_avail[0]);

  matrix_bank #(.width(width)) u_bank0 (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(w_hs & ~r_wr_sel), .i_wr_idx(r_beat), .i_wr_data(s_data),
    .i_m_bit1(s_m_bit1), .i_m_bit2(s_m_bit2), .i_flag(s_flag),
    .i_set_full(w_set[0]), .i_clr(w_hold_end & ~r_rd_sel),
    .o_a(w_a0), .o_b(w_b0), .o_m_bit1(w_m1_0), .o_m_bit2(w_m2_0),
    .o_flag(w_fl_0), .o_full(w_full[0])
  );

  matrix_bank #(.width(width)) u_bank1 (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(w_hs & r_wr_sel), .i_wr_idx(r_beat), .i_wr_data(s_data),
    .i_m_bit1(s_m_bit1), .i_m_bit2(s_m_bit2), .i_flag(s_flag),
    .i_set_full(w_set[1]), .i_clr(w_hold_end & r_rd_sel),
    .o_a(w_a1), .o_b(w_b1), .o_m_bit1(w_m1_1), .o_m_bit2(w_m2_1),
    .o_flag(w_fl_1), .o_full(w_full[1])
  );

  assign w_pa  = r_rd_sel ? w_a1   : w_a0;
  assign w_pb  = r_rd_sel ? w_b1   : w_b0;
  assign w_pm1 = r_rd_sel ? w_m1_1 : w_m1_0;
  assign w_pm2 = r_rd_sel ? w_m2_1 : w_m2_0;
  assign w_pfl = r_rd_sel ? w_fl_1 : w_fl_0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      if (w_last)
        r_wr_sel <= ~r_wr_sel;
      if (w_hold_end)
        r_rd_sel <= ~r_rd_sel;
    end
  end
`else
  logic w_full;

  assign s_ready      = r_ready_en & ~w_full;
  // A single bank cannot be refilled while held, so a hold never chains.
  assign w_next_avail = ~r_op_valid & (w_full | w_last);

  matrix_bank #(.width(width)) u_bank (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(w_hs), .i_wr_idx(r_beat), .i_wr_data(s_data),
    .i_m_bit1(s_m_bit1), .i_m_bit2(s_m_bit2), .i_flag(s_flag),
    .i_set_full(w_last), .i_clr(w_hold_end),
    .o_a(w_pa), .o_b(w_pb), .o_m_bit1(w_pm1), .o_m_bit2(w_pm2),
    .o_flag(w_pfl), .o_full(w_full)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en  <= 1'b0;
      r_beat      <= '0;
      r_rd_state  <= RD_IDLE;
      r_op_valid  <= 1'b0;
      r_res_valid <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_hs)
        r_beat <= r_beat + BEAT_W'(1);
      case (r_rd_state)
        RD_IDLE: begin
          if (w_next_avail) begin
            r_rd_state  <= RD_HOLD;
            r_op_valid  <= 1'b1;
            r_hold_cnt  <= '0;
            r_res_valid <= HOLD_ONE;
          end
        end
        RD_HOLD: begin
          if (w_hold_end) begin
            r_hold_cnt <= '0;
            if (w_next_avail) begin
              r_res_valid <= HOLD_ONE;
            end else begin
              r_rd_state  <= RD_IDLE;
              r_op_valid  <= 1'b0;
              r_res_valid <= 1'b0;
            end
          end else begin
            r_hold_cnt  <= r_hold_cnt + CW'(1);
            r_res_valid <= ((r_hold_cnt + CW'(1)) == HOLD_LAST);
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        A[i][j] = w_pa[i][j];
        B[i][j] = w_pb[i][j];
      end
    end
  end

  assign m_bit1    = w_pm1;
  assign m_bit2    = w_pm2;
  assign flag      = w_pfl;
  assign op_valid  = r_op_valid;
  assign res_valid = r_res_valid;
endmodule

// File: tb/tb_matrix_load8.sv
// Directed bench for matrix_load8 (single-bank default, PINGPONG_EN variant via the same macro).
module tb_matrix_load8;
  localparam int W  = 16;
  localparam int EW = 2 * W;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [EW-1:0] s_data = '0;
  logic [4:0]    s_m_bit1 = '0;
  logic [4:0]    s_m_bit2 = '0;
  logic          s_flag = 1'b0;
  logic [EW-1:0] A [8][8];
  logic [EW-1:0] B [8][8];
  logic [4:0]    m_bit1;
  logic [4:0]    m_bit2;
  logic          flag;
  logic          op_valid;
  logic          res_valid;

  int            errors = 0;
  int            checks = 0;
  logic [31:0]   fr [128];
  logic [4:0]    f_m1, f_m2;
  logic          f_fl;

  always #5 clk = ~clk;

  matrix_load8 #(.width(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_m_bit1(s_m_bit1), .s_m_bit2(s_m_bit2), .s_flag(s_flag),
    .A(A), .B(B), .m_bit1(m_bit1), .m_bit2(m_bit2), .flag(flag),
    .op_valid(op_valid), .res_valid(res_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_frame(input int kind);
    for (int k = 0; k < 128; k++) begin
      case (kind)
        1: fr[k] = (k < 64) ? 32'(k) : ((((k - 64) / 8) == ((k - 64) % 8)) ? 32'd1 : 32'd0);
        2: fr[k] = (k < 64) ? 32'h1000_0000 + 32'(k * 3) : 32'hF000_0000 + 32'(k ^ 85);
        3: fr[k] = 32'h2000_0000 + 32'(k);
        4: fr[k] = 32'h3000_0000 + 32'(127 - k);
        default: fr[k] = 32'h4000_0000 + 32'(k * 7);
      endcase
    end
    case (kind)
      1: begin f_m1 = 5'd10; f_m2 = 5'd3;  f_fl = 1'b1; end
      2: begin f_m1 = 5'd7;  f_m2 = 5'd21; f_fl = 1'b0; end
      3: begin f_m1 = 5'd4;  f_m2 = 5'd9;  f_fl = 1'b1; end
      4: begin f_m1 = 5'd17; f_m2 = 5'd2;  f_fl = 1'b0; end
      default: begin f_m1 = 5'd12; f_m2 = 5'd30; f_fl = 1'b1; end
    endcase
  endtask

  // Non-zero beats carry inverted format so any late capture is visible.
  task automatic drive_beat(input int k);
    s_valid = 1'b1;
    s_data  = fr[k];
    if (k == 0) begin
      s_m_bit1 = f_m1; s_m_bit2 = f_m2; s_flag = f_fl;
    end else begin
      s_m_bit1 = ~f_m1; s_m_bit2 = ~f_m2; s_flag = ~f_fl;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("ready_timeout", 32'(s_ready), 32'd1);
  endtask

  task automatic send_beats(input int first, input int last, input bit gaps);
    for (int k = first; k <= last; k++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 3));
        for (int c = 0; c < g; c++) begin
          s_valid = 1'b0;
          s_data  = $urandom;
          @(negedge clk);
        end
      end
      drive_beat(k);
      wait_ready();
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (A[i][j] !== fr[i*8+j]) bad++;
        if (B[i][j] !== fr[64+i*8+j]) bad++;
      end
    end
    chk({tag, "_bad_elems"}, 32'(bad), 32'd0);
    chk({tag, "_m_bit1"}, 32'(m_bit1), 32'(f_m1));
    chk({tag, "_m_bit2"}, 32'(m_bit2), 32'(f_m2));
    chk({tag, "_flag"}, 32'(flag), 32'(f_fl));
  endtask

  task automatic hold_check(input string tag);
    logic [31:0] a25;
    a25 = fr[21];
    for (int k = 0; k < H; k++) begin
      chk({tag, "_hold_op_valid"}, 32'(op_valid), 32'd1);
      chk({tag, "_hold_res_valid"}, 32'(res_valid), (k == H - 1) ? 32'd1 : 32'd0);
      chk({tag, "_hold_A25"}, A[2][5], a25);
`ifdef PINGPONG_EN
      chk({tag, "_hold_s_ready"}, 32'(s_ready), 32'd1);
`else
      chk({tag, "_hold_s_ready"}, 32'(s_ready), 32'd0);
`endif
      @(negedge clk);
    end
    chk({tag, "_op_valid_drop"}, 32'(op_valid), 32'd0);
    chk({tag, "_s_ready_back"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a25_prev;
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_A00", A[0][0], 32'd0);
    chk("rst_B77", B[7][7], 32'd0);
    chk("rst_m_bit1", 32'(m_bit1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_reset", 32'(s_ready), 32'd1);

    // Frame 1: A = index, B = identity
    fill_frame(1);
    send_beats(0, 126, 1'b0);
    chk("f1_op_valid_before_last", 32'(op_valid), 32'd0);
    send_beats(127, 127, 1'b0);
    chk("f1_op_valid_rise", 32'(op_valid), 32'd1);
    chk("f1_A77", A[7][7], 32'd63);
    chk("f1_B33", B[3][3], 32'd1);
    chk("f1_B34", B[3][4], 32'd0);
    chk("f1_m_bit1", 32'(m_bit1), 32'd10);
    check_frame("f1");
    hold_check("f1");

    // Frame 2: random valid gaps, format fields change after beat 0
    fill_frame(2);
    send_beats(0, 127, 1'b1);
    chk("f2_op_valid_rise", 32'(op_valid), 32'd1);
    check_frame("f2");
    hold_check("f2");

    // Frame 3 then frame 4 offered immediately
    fill_frame(3);
    send_beats(0, 127, 1'b0);
    check_frame("f3");
    a25_prev = fr[21];
    fill_frame(4);
`ifdef PINGPONG_EN
    for (int k = 0; k < H; k++) begin
      drive_beat(k);
      chk("pp_load_s_ready", 32'(s_ready), 32'd1);
      chk("pp_load_op_valid", 32'(op_valid), 32'd1);
      chk("pp_load_res_valid", 32'(res_valid), (k == H - 1) ? 32'd1 : 32'd0);
      chk("pp_load_A25_stable", A[2][5], a25_prev);
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("pp_op_valid_gap", 32'(op_valid), 32'd0);
    send_beats(H, 127, 1'b0);
`else
    drive_beat(0);
    for (int k = 0; k < H; k++) begin
      chk("stall_s_ready", 32'(s_ready), 32'd0);
      chk("stall_res_valid", 32'(res_valid), (k == H - 1) ? 32'd1 : 32'd0);
      chk("stall_A25_stable", A[2][5], a25_prev);
      @(negedge clk);
    end
    chk("stall_s_ready_release", 32'(s_ready), 32'd1);
    chk("stall_op_valid_drop", 32'(op_valid), 32'd0);
    send_beats(0, 127, 1'b0);
`endif
    chk("f4_op_valid_rise", 32'(op_valid), 32'd1);
    check_frame("f4");
    hold_check("f4");

    // Reset asserted while beat 40 of frame 5 is offered
    fill_frame(5);
    send_beats(0, 39, 1'b0);
    drive_beat(40);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_op_valid", 32'(op_valid), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_A00", A[0][0], 32'd0);
    chk("mid_rst_B77", B[7][7], 32'd0);
    chk("mid_rst_m_bit1", 32'(m_bit1), 32'd0);
    chk("mid_rst_flag", 32'(flag), 32'd0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    send_beats(0, 127, 1'b0);
    chk("f5_op_valid_rise", 32'(op_valid), 32'd1);
    check_frame("f5");
    hold_check("f5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
